riscv_trace_checker: RTL

- Synthesizable, parametrised retirement checker that sits beside the RISC-V core wrapper.
- Compares each retired instruction (PC, register write-enable, rd, write data) against an expected trace held in an internal table.
- Reports pass or fail with the first mismatch index and cause.
- Runs a no-retire watchdog, so regressions and on-board self-tests get a pass/fail verdict without waveform inspection.

---
 rtl/riscv_trace_checker_if.sv | 47 ++++
 rtl/riscv_trace_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_checker_if.sv
// Connection bundle for riscv_trace_checker: expected-trace load port, run control,
// retirement stream from the core and the registered verdict/status outputs.
interface riscv_trace_checker_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            exp_we;
  logic [AW-1:0]   exp_addr;
  logic [XLEN-1:0] exp_pc;
  logic            exp_rd_we;
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_data;
  logic            start;
  logic [AW:0]     exp_len;
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic            retire_rd_we;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_data;

  logic            busy;
  logic            done;
  logic            pass;
  logic            fail;
  logic [2:0]      fail_code;
  logic [AW:0]     fail_idx;
  logic [XLEN-1:0] fail_pc;
  logic [XLEN-1:0] fail_data;
  logic [AW:0]     commit_cnt;
  logic [15:0]     cycle_cnt;

  modport master (
    output exp_we, exp_addr, exp_pc, exp_rd_we, exp_rd, exp_data, start, exp_len,
           retire_valid, retire_pc, retire_rd_we, retire_rd, retire_data,
    input  busy, done, pass, fail, fail_code, fail_idx, fail_pc, fail_data,
           commit_cnt, cycle_cnt
  );

  modport slave (
    input  exp_we, exp_addr, exp_pc, exp_rd_we, exp_rd, exp_data, start, exp_len,
           retire_valid, retire_pc, retire_rd_we, retire_rd, retire_data,
    output busy, done, pass, fail, fail_code, fail_idx, fail_pc, fail_data,
           commit_cnt, cycle_cnt
  );
endinterface

// File: rtl/riscv_trace_checker.sv
// Retirement checker: compares each retired instruction against a preloaded expected
// trace, reports the first mismatch (index, cause, PC, data) and runs a no-retire watchdog.
module riscv_trace_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_trace_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_PC      = 3'd1;
  localparam logic [2:0] C_WE      = 3'd2;
  localparam logic [2:0] C_RD      = 3'd3;
  localparam logic [2:0] C_DATA    = 3'd4;
  localparam logic [2:0] C_TIMEOUT = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          r_tab [DEPTH];
  entry_t          r_ovr_entry;
  logic            r_ovr_valid;
  logic [AW-1:0]   r_ovr_addr;
  logic [1:0]      r_state;
  logic [AW:0]     r_idx;
  logic [AW:0]     r_eff_len;
  logic [WW-1:0]   r_wdog;
  logic [15:0]     r_cycle_cnt;
  logic [2:0]      r_fail_code;
  logic [AW:0]     r_fail_idx;
  logic [XLEN-1:0] r_fail_pc;
  logic [XLEN-1:0] r_fail_data;

  entry_t          w_wr_entry;
  entry_t          w_exp;
  logic            w_can_write;
  logic [AW:0]     w_eff_len;
  logic [AW:0]     w_idx_nxt;
  logic [2:0]      w_cause;

  assign w_wr_entry  = '{pc: bus.exp_pc, rd_we: bus.exp_rd_we, rd: bus.exp_rd, data: bus.exp_data};
  assign w_can_write = bus.exp_we && (r_state != S_RUN);
  assign w_eff_len   = (bus.exp_len > DEPTH_L) ? DEPTH_L : bus.exp_len;
  assign w_idx_nxt   = r_idx + 1'b1;

  // An entry rewritten in the same cycle as start keeps its pre-write value for that run.
  assign w_exp = (r_ovr_valid && (r_ovr_addr == r_idx[AW-1:0])) ? r_ovr_entry
                                                                 : r_tab[r_idx[AW-1:0]];

  always_comb begin
    w_cause = C_NONE;
    if (bus.retire_pc != w_exp.pc)
      w_cause = C_PC;
    else if (bus.retire_rd_we != w_exp.rd_we)
      w_cause = C_WE;
    else if (w_exp.rd_we && (bus.retire_rd != w_exp.rd))
      w_cause = C_RD;
    else if (w_exp.rd_we && (w_exp.rd != 5'd0) && (bus.retire_data != w_exp.data))
      w_cause = C_DATA;
  end

  // NOTE: the trace table is plain storage with no reset, so it maps onto RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (w_can_write)
      r_tab[bus.exp_addr] <= w_wr_entry;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_eff_len   <= '0;
      r_wdog      <= '0;
      r_cycle_cnt <= '0;
      r_fail_code <= C_NONE;
      r_fail_idx  <= '0;
      r_fail_pc   <= '0;
      r_fail_data <= '0;
      r_ovr_valid <= 1'b0;
      r_ovr_addr  <= '0;
      r_ovr_entry <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_cycle_cnt != 16'hFFFF)
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (!bus.retire_valid) begin
            if (r_wdog == WDOG_MAX) begin
              r_state     <= S_FAIL;
              r_fail_code <= C_TIMEOUT;
              r_fail_idx  <= r_idx;
              r_fail_pc   <= '0;
              r_fail_data <= '0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end else begin
            r_wdog <= '0;
            if (w_cause != C_NONE) begin
              r_state     <= S_FAIL;
              r_fail_code <= w_cause;
              r_fail_idx  <= r_idx;
              r_fail_pc   <= bus.retire_pc;
              r_fail_data <= bus.retire_data;
            end else begin
              r_idx <= w_idx_nxt;
              if (w_idx_nxt == r_eff_len)
                r_state <= S_PASS;
            end
          end
        end
        default: begin
          if (bus.start) begin
            r_idx       <= '0;
            r_eff_len   <= w_eff_len;
            r_wdog      <= '0;
            r_cycle_cnt <= '0;
            r_fail_code <= C_NONE;
            r_fail_idx  <= '0;
            r_fail_pc   <= '0;
            r_fail_data <= '0;
            r_ovr_valid <= bus.exp_we;
            r_ovr_addr  <= bus.exp_addr;
            r_ovr_entry <= r_tab[bus.exp_addr];
            r_state     <= (w_eff_len == '0) ? S_PASS : S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = (r_state == S_PASS) || (r_state == S_FAIL);
  assign bus.pass       = (r_state == S_PASS);
  assign bus.fail       = (r_state == S_FAIL);
  assign bus.fail_code  = r_fail_code;
  assign bus.fail_idx   = r_fail_idx;
  assign bus.fail_pc    = r_fail_pc;
  assign bus.fail_data  = r_fail_data;
  assign bus.commit_cnt = r_idx;
  assign bus.cycle_cnt  = r_cycle_cnt;

endmodule
